gate_sweep_checker: RTL and testbench

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

---
 rtl/gate_chk_pkg.sv | 34 +++
 rtl/gate_sweep_checker.sv | 149 ++++++++++++++
 tb/tb_gate_sweep_checker.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/gate_chk_pkg.sv
// Shared definitions for the gate-bank sweep checker.
//   state_t      : sweep controller states (IDLE, WAIT, CHECK, DONE)
//   GY_*         : bit positions of each gate output inside gate_y
//   EXP_Y        : expected gate_y for each {a,b} vector
//   expected_y() : table lookup for a given {a,b} vector
package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int GY_AND  = 0;
    localparam int GY_OR   = 1;
    localparam int GY_NOTA = 2;
    localparam int GY_NAND = 3;
    localparam int GY_NOR  = 4;
    localparam int GY_XOR  = 5;

    // Indexed by {a,b}; bit order matches gate_y.
    localparam logic [5:0] EXP_Y [0:3] = '{
        6'b011100,  // a=0 b=0
        6'b101110,  // a=0 b=1
        6'b101010,  // a=1 b=0
        6'b000011   // a=1 b=1
    };

    function automatic logic [5:0] expected_y(input logic [1:0] vec);
        return EXP_Y[vec];
    endfunction

endpackage

// File: rtl/gate_sweep_checker.sv
// Drives all four {a,b} vectors into an external two-input gate bank, waits
// SETTLE cycles after each vector, compares the six gate outputs against the
// truth table and reports the accumulated result.
//
// Ports
//   clk            : clock, rising edge
//   rst_n          : asynchronous active-low reset
//   start          : request a sweep (only looked at while idle)
//   gate_y[5:0]    : gate-bank outputs {xor,nor,nand,not(a),or,and}
//   a, b           : registered gate-bank inputs
//   busy           : sweep in progress
//   done           : one-cycle pulse when a sweep completes
//   pass           : last sweep had no mismatch (held until the next start)
//   fail_mask[5:0] : OR of mismatch bits over the last sweep
//   first_fail_vec : {a,b} of the first mismatching vector, 0 on pass
//   state_dbg[1:0] : current controller state (state_t encoding)
//
// Handshake: start is a level request; a sweep begins on the first rising
// edge where start=1 and the block is idle. Requests seen while busy are
// dropped, never queued. done marks the result outputs as valid; they stay
// valid until the next accepted start.
module gate_sweep_checker
    import gate_chk_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] gate_y,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [5:0] fail_mask,
    output logic [1:0] first_fail_vec,
    output logic [1:0] state_dbg
);

    localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

    state_t     state_q, state_d;
    logic [1:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [5:0] mask_q, mask_d;
    logic [1:0] first_q, first_d;
    logic [5:0] mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            vec_q   <= 2'b00;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            mask_q  <= 6'd0;
            first_q <= 2'b00;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            mask_q  <= mask_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        mask_d   = mask_q;
        first_d  = first_q;
        mismatch = gate_y ^ expected_y(vec_q);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d  = 6'd0;
                    pass_d  = 1'b0;
                    first_d = 2'b00;
                    vec_d   = 2'b00;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    cnt_d   = SETTLE_CNT;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                // Counter is loaded with SETTLE, so WAIT lasts SETTLE cycles.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_CHECK;
                end
            end

            ST_CHECK: begin
                mask_d = mask_q | mismatch;
                // An all-zero mask so far means no earlier vector failed.
                if ((mismatch != 6'd0) && (mask_q == 6'd0)) begin
                    first_d = vec_q;
                end
                if (vec_q != 2'b11) begin
                    vec_d   = vec_q + 2'b01;
                    {a_d, b_d} = vec_q + 2'b01;
                    cnt_d   = SETTLE_CNT;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done_d  = 1'b1;
                pass_d  = (mask_q == 6'd0);
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign a              = a_q;
    assign b              = b_q;
    assign busy           = (state_q != ST_IDLE);
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_mask      = mask_q;
    assign first_fail_vec = first_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
module tb_gate_sweep_checker;
    import gate_chk_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Index 0: SETTLE=2 instance, index 1: SETTLE=1 instance.
    logic       start [2];
    logic [5:0] gate_y [2];
    logic       a [2];
    logic       b [2];
    logic       busy [2];
    logic       done [2];
    logic       pass [2];
    logic [5:0] fmask [2];
    logic [1:0] ffv [2];
    logic [1:0] sdbg [2];

    // Gate-bank fault selection: 0 good, 1 xor stuck-0, 2 and/nand swapped,
    // 3 random per-vector flipped outputs.
    int         mode [2];
    logic [5:0] fault_tab [2][4];

    int n_checks;
    int n_pass;

    // Ideal gate bank from boolean operators.
    function automatic logic [5:0] ideal_y(input logic [1:0] v);
        logic x, y;
        x = v[1];
        y = v[0];
        return {x ^ y, ~(x | y), ~(x & y), ~x, x | y, x & y};
    endfunction

    function automatic logic [5:0] bank_y(input int m, input logic [5:0] flt, input logic [1:0] v);
        logic [5:0] y;
        y = ideal_y(v);
        case (m)
            1: y[5] = 1'b0;
            2: begin y[0] = ~(v[1] & v[0]); y[3] = v[1] & v[0]; end
            3: y = y ^ flt;
            default: ;
        endcase
        return y;
    endfunction

    assign gate_y[0] = bank_y(mode[0], fault_tab[0][{a[0], b[0]}], {a[0], b[0]});
    assign gate_y[1] = bank_y(mode[1], fault_tab[1][{a[1], b[1]}], {a[1], b[1]});

    gate_sweep_checker #(.SETTLE(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .gate_y(gate_y[0]),
        .a(a[0]), .b(b[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
        .fail_mask(fmask[0]), .first_fail_vec(ffv[0]), .state_dbg(sdbg[0])
    );

    gate_sweep_checker #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .gate_y(gate_y[1]),
        .a(a[1]), .b(b[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
        .fail_mask(fmask[1]), .first_fail_vec(ffv[1]), .state_dbg(sdbg[1])
    );

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic chk_all_zero(input string pfx, input int i);
        chk({pfx, "_a"}, a[i], 0);
        chk({pfx, "_b"}, b[i], 0);
        chk({pfx, "_busy"}, busy[i], 0);
        chk({pfx, "_done"}, done[i], 0);
        chk({pfx, "_pass"}, pass[i], 0);
        chk({pfx, "_fail_mask"}, fmask[i], 0);
        chk({pfx, "_first_fail"}, ffv[i], 0);
        chk({pfx, "_state"}, sdbg[i], ST_IDLE);
    endtask

    // ---------------- driver + scoreboard ----------------
    // Called at a negedge; returns at a negedge.
    task automatic sweep(input int i, input int m, input bit hold);
        logic [5:0] exp_mask, mm;
        logic [1:0] exp_first;
        logic       have_first;
        logic [1:0] seq_q[$];
        int         done_edge, lat;

        mode[i] = m;
        for (int v = 0; v < 4; v++)
            fault_tab[i][v] = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(1, 63)) : 6'd0;

        // Reference result for the whole sweep.
        exp_mask = 6'd0; exp_first = 2'b00; have_first = 1'b0;
        for (int v = 0; v < 4; v++) begin
            mm = bank_y(m, fault_tab[i][v], 2'(v)) ^ ideal_y(2'(v));
            exp_mask |= mm;
            if (mm != 6'd0 && !have_first) begin exp_first = 2'(v); have_first = 1'b1; end
        end
        lat = 4 * (((i == 0) ? 2 : 1) + 1) + 1;

        start[i] = 1'b1;
        @(posedge clk);  // edge 0
        @(negedge clk);
        if (!hold) start[i] = 1'b0;
        chk("busy_after_start", busy[i], 1);
        chk("pass_cleared", pass[i], 0);
        seq_q.push_back({a[i], b[i]});

        done_edge = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (seq_q[$] != {a[i], b[i]}) seq_q.push_back({a[i], b[i]});
            if (done[i]) begin done_edge = k; break; end
        end

        chk("done_latency", done_edge, lat);
        chk("busy_at_done", busy[i], 0);
        chk("pass", pass[i], (exp_mask == 6'd0));
        chk("fail_mask", fmask[i], exp_mask);
        chk("first_fail_vec", ffv[i], exp_first);
        chk("ab_seq_len", seq_q.size(), 4);
        for (int j = 0; j < seq_q.size() && j < 4; j++)
            chk("ab_seq_val", seq_q[j], j);

        if (!hold) begin
            @(posedge clk);
            @(negedge clk);
            chk("done_one_cycle", done[i], 0);
            chk("pass_held", pass[i], (exp_mask == 6'd0));
            chk("mask_held", fmask[i], exp_mask);
        end
    endtask

    task automatic reset_mid_sweep();
        int seen_done;
        start[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start[0] = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (a[0] == 1'b1 && b[0] == 1'b0) break;
            @(posedge clk);
            @(negedge clk);
        end
        chk("reached_vec10", {a[0], b[0]}, 2'b10);
        chk("in_wait_vec10", sdbg[0], ST_WAIT);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_rst", 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (done[0]) seen_done++;
            if (busy[0]) seen_done += 100;
        end
        chk("idle_after_reset", seen_done, 0);
        sweep(0, 0, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            mode[i]  = 0;
            for (int v = 0; v < 4; v++) fault_tab[i][v] = 6'd0;
        end
        repeat (3) @(negedge clk);
        chk_all_zero("reset0", 0);
        chk_all_zero("reset1", 1);
        rst_n = 1'b1;
        @(negedge clk);

        sweep(0, 0, 1'b0);   // good bank
        sweep(0, 1, 1'b0);   // xor stuck at 0
        sweep(0, 2, 1'b0);   // and/nand swapped

        // start held high through two sweeps, released during the third
        sweep(0, 0, 1'b1);
        sweep(0, 1, 1'b1);
        sweep(0, 0, 1'b0);

        reset_mid_sweep();

        // SETTLE=1: failing then passing sweep
        sweep(1, 2, 1'b0);
        sweep(1, 0, 1'b0);

        for (int r = 0; r < 10; r++)
            sweep(int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
